dma_irq_controller: RTL and testbench

Interrupt capture and masking stage downstream of the DMA engine's `readerDone`/`writerDone` outputs, upstream of the simulator's interrupt inputs. Converts completion pulses from the DMA into sticky, individually maskable pending bits. Software reads and clears them through an AXI4-Lite subordinate port on the control bus. Drives one level-sensitive line per source plus a combined line.

---
 rtl/dma_irq_controller_pkg.sv | 28 ++
 rtl/dma_irq_controller_if.sv | 45 ++++
 rtl/dma_irq_controller_axi_lite_reg_port.sv | 133 +++++++++++++
 rtl/dma_irq_controller.sv | 121 ++++++++++++
 tb/tb_dma_irq_controller.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_irq_controller_pkg.sv
// rtl/dma_irq_controller_pkg.sv - shared constants and types for dma_irq_controller
// Contents: register word offsets, AXI response encoding, source limit,
//           byte-strobe expansion helper.
package dma_irq_pkg;

  localparam int MaxIrqCount = 32;

  // Word offsets, compared against address bits [3:2].
  localparam logic [1:0] PendingOffset = 2'd0;
  localparam logic [1:0] MaskOffset    = 2'd1;
  localparam logic [1:0] RawOffset     = 2'd2;
  localparam logic [1:0] ForceOffset   = 2'd3;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  // Expands a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dma_irq_controller_if.sv
// rtl/dma_irq_controller_if.sv - AXI4-Lite control bus bundle for dma_irq_controller
// Signals: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//          B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//          R (rdata/rresp/rvalid/rready).
// Modports: master (bus initiator), slave (register block).
interface dma_irq_controller_if #(
  parameter int AddrWidth = 32
);
  logic [AddrWidth-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [AddrWidth-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/dma_irq_controller_axi_lite_reg_port.sv
// rtl/dma_irq_controller_axi_lite_reg_port.sv - AXI4-Lite handshake front end with AW/W holds
// Ports: clock_i, reset_i (sync, active high); bus (AXI4-Lite slave modport);
//        wr_en_o/wr_addr_o/wr_data_o/wr_strb_o single-cycle write strobe, wr_err_i decode result;
//        rd_en_o/rd_addr_o single-cycle read strobe, rd_data_i/rd_err_i same-cycle read result.
module axi_lite_reg_port
  import dma_irq_pkg::*;
#(
  parameter int AddrWidth = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  dma_irq_controller_if.slave  bus,
  output logic                 wr_en_o,
  output logic [AddrWidth-1:0] wr_addr_o,
  output logic [31:0]          wr_data_o,
  output logic [3:0]           wr_strb_o,
  input  logic                 wr_err_i,
  output logic                 rd_en_o,
  output logic [AddrWidth-1:0] rd_addr_o,
  input  logic [31:0]          rd_data_i,
  input  logic                 rd_err_i
);

  logic                 aw_full_q, aw_full_d;
  logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
  logic                 w_full_q, w_full_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [3:0]           w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;
  axi_resp_e            bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  axi_resp_e            rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic unused_prot;

  assign unused_prot = ^{bus.awprot, bus.arprot};

  // Readies are gated by reset so they only rise once reset is released.
  assign bus.awready = ~reset_i & ~aw_full_q & ~bvalid_q;
  assign bus.wready  = ~reset_i & ~w_full_q & ~bvalid_q;
  assign bus.arready = ~reset_i & ~rvalid_q;

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;
  assign ar_hs = bus.arvalid & bus.arready;

  // A channel counts as held either from its register or from a handshake
  // this cycle, so simultaneous AW+W commit without an extra cycle.
  assign wr_en_o   = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign wr_addr_o = aw_full_q ? aw_addr_q : bus.awaddr;
  assign wr_data_o = w_full_q ? w_data_q : bus.wdata;
  assign wr_strb_o = w_full_q ? w_strb_q : bus.wstrb;

  assign rd_en_o   = ar_hs;
  assign rd_addr_o = bus.araddr;

  assign bus.bvalid = bvalid_q;
  assign bus.bresp  = bresp_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end

    // Readies are low while bvalid is high, so a commit never overlaps a
    // pending response.
    if (wr_en_o) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err_i ? SLVERR : OKAY;
    end else if (bvalid_q && bus.bready) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_i;
      rresp_d  = rd_err_i ? SLVERR : OKAY;
    end else if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/dma_irq_controller.sv
// rtl/dma_irq_controller.sv - sticky, maskable interrupt capture for DMA completion lines
// Ports: clock_i, reset_i (sync, active high); irq_in_i raw completion lines
//        (bit 0 writerDone, bit 1 readerDone); irq_out_o registered pending & mask;
//        irq_any_o registered OR of irq_out_o; bus AXI4-Lite slave for PENDING (0x0, RW1C),
//        MASK (0x4, RW), RAW (0x8, RO), FORCE (0xC, W1S into PENDING, reads 0).
module dma_irq_controller
  import dma_irq_pkg::*;
#(
  parameter int IrqCount  = 2,
  parameter int AddrWidth = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [IrqCount-1:0] irq_in_i,
  output logic [IrqCount-1:0] irq_out_o,
  output logic                irq_any_o,
  dma_irq_controller_if.slave bus
);

  logic                 wr_en;
  logic [AddrWidth-1:0] wr_addr;
  logic [31:0]          wr_data;
  logic [3:0]           wr_strb;
  logic                 wr_err;
  logic                 rd_en;
  logic [AddrWidth-1:0] rd_addr;
  logic [MaxIrqCount-1:0] rd_word;
  logic                 rd_err;

  logic [IrqCount-1:0] irq_prev_q;
  logic [IrqCount-1:0] pending_q, pending_d;
  logic [IrqCount-1:0] mask_q, mask_d;
  logic [IrqCount-1:0] irq_out_q;
  logic                irq_any_q;

  logic [IrqCount-1:0] rise;
  logic [IrqCount-1:0] clr;
  logic [IrqCount-1:0] frc;
  logic [31:0]         byte_mask;
  logic [31:0]         wr_bits;
  logic                unused_bits;

  axi_lite_reg_port #(
    .AddrWidth(AddrWidth)
  ) u_port (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .bus      (bus),
    .wr_en_o  (wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .wr_strb_o(wr_strb),
    .wr_err_i (wr_err),
    .rd_en_o  (rd_en),
    .rd_addr_o(rd_addr),
    .rd_data_i(rd_word),
    .rd_err_i (rd_err)
  );

  // Only offsets 0x0..0xC exist; anything with higher bits set is unmapped.
  assign wr_err = |wr_addr[AddrWidth-1:4];
  assign rd_err = |rd_addr[AddrWidth-1:4];

  assign byte_mask = strb_to_mask(wr_strb);
  assign wr_bits   = wr_data & byte_mask;

  // Reads have no side effects, so rd_en and the byte-offset bits go unused.
  assign unused_bits = ^{rd_en, wr_addr[1:0], rd_addr[1:0], wr_bits, byte_mask};

  assign rise = irq_in_i & ~irq_prev_q;

  always_comb begin
    clr    = '0;
    frc    = '0;
    mask_d = mask_q;
    if (wr_en && !wr_err) begin
      case (wr_addr[3:2])
        PendingOffset: clr    = wr_bits[IrqCount-1:0];
        MaskOffset:    mask_d = (mask_q & ~byte_mask[IrqCount-1:0]) | wr_bits[IrqCount-1:0];
        ForceOffset:   frc    = wr_bits[IrqCount-1:0];
        default:       ;
      endcase
    end
  end

  // Set has priority over a same-cycle W1C.
  assign pending_d = (pending_q & ~clr) | rise | frc;

  // Reads see state before this edge, so a same-cycle set is not visible yet.
  always_comb begin
    rd_word = '0;
    if (!rd_err) begin
      case (rd_addr[3:2])
        PendingOffset: rd_word[IrqCount-1:0] = pending_q;
        MaskOffset:    rd_word[IrqCount-1:0] = mask_q;
        RawOffset:     rd_word[IrqCount-1:0] = irq_in_i;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_out_q  <= '0;
      irq_any_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq_in_i;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_out_q  <= pending_q & mask_q;
      irq_any_q  <= |(pending_q & mask_q);
    end
  end

  assign irq_out_o = irq_out_q;
  assign irq_any_o = irq_any_q;

endmodule

// File: tb/tb_dma_irq_controller.sv
// tb/tb_dma_irq_controller.sv - self-checking bench for dma_irq_controller
module tb_dma_irq_controller;
  import dma_irq_pkg::*;

  localparam int IrqCount = 2;
  localparam int NumVec   = 24;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [1:0]  exp_irq;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [IrqCount-1:0] irq_in = '0;
  logic [IrqCount-1:0] irq_out;
  logic                irq_any;

  int checks = 0;
  int errors = 0;

  vec_t vecs[NumVec];
  exp_t sb_q[$];

  dma_irq_controller_if #(.AddrWidth(32)) bus ();

  dma_irq_controller #(
    .IrqCount (IrqCount),
    .AddrWidth(32)
  ) dut (
    .clock_i  (clock),
    .reset_i  (reset),
    .irq_in_i (irq_in),
    .irq_out_o(irq_out),
    .irq_any_o(irq_any),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      e.data = '0;
      e.resp = '0;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    bit   aw_done = 0;
    bit   w_done  = 0;
    bit   aw_fire, w_fire;
    exp_t e;
    e.data = '0;
    e.resp = resp;
    sb_q.push_back(e);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b0;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      step();
      if (aw_fire) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1; bus.wvalid  = 1'b0; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check($sformatf("aw_w_accept@%h", addr), {30'd0, aw_done, w_done}, 32'd3);
    check($sformatf("b_latency@%h", addr), bus.bvalid, 1);
    for (int i = 0; i < 20 && !bus.bvalid; i++) step();
    pop_exp(e);
    check($sformatf("bresp@%h", addr), bus.bresp, e.resp);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check($sformatf("b_done@%h", addr), bus.bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] resp);
    bit   done = 0;
    bit   fire;
    exp_t e;
    e.data = exp_data;
    e.resp = resp;
    sb_q.push_back(e);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      fire = bus.arvalid && bus.arready;
      step();
      if (fire) begin done = 1; bus.arvalid = 1'b0; end
    end
    bus.arvalid = 1'b0;
    check($sformatf("ar_accept@%h", addr), {31'd0, done}, 32'd1);
    check($sformatf("r_latency@%h", addr), bus.rvalid, 1);
    for (int i = 0; i < 20 && !bus.rvalid; i++) step();
    pop_exp(e);
    check($sformatf("rdata@%h", addr), bus.rdata, e.data);
    check($sformatf("rresp@%h", addr), bus.rresp, e.resp);
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    check($sformatf("r_done@%h", addr), bus.rvalid, 0);
  endtask

  initial begin
    exp_t e;

    // write, addr, data, strb, exp_data, exp_resp, exp_irq
    // Starting state: irq_in = 01 held, PENDING = 01, MASK = 00.
    vecs[0]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h1, 2'b00, 2'b00};
    vecs[1]  = '{1'b0, 32'h8,        32'h0,        4'h0, 32'h1, 2'b00, 2'b00};
    vecs[2]  = '{1'b1, 32'h4,        32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00, 2'b01};
    vecs[3]  = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h3, 2'b00, 2'b01};
    vecs[4]  = '{1'b1, 32'h4,        32'h0,        4'h0, 32'h0, 2'b00, 2'b01};
    vecs[5]  = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h3, 2'b00, 2'b01};
    vecs[6]  = '{1'b1, 32'h4,        32'h0,        4'hE, 32'h0, 2'b00, 2'b01};
    vecs[7]  = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h3, 2'b00, 2'b01};
    vecs[8]  = '{1'b1, 32'hC,        32'h2,        4'hF, 32'h0, 2'b00, 2'b11};
    vecs[9]  = '{1'b0, 32'hC,        32'h0,        4'h0, 32'h0, 2'b00, 2'b11};
    vecs[10] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h3, 2'b00, 2'b11};
    vecs[11] = '{1'b1, 32'h8,        32'h0,        4'hF, 32'h0, 2'b00, 2'b11};
    vecs[12] = '{1'b0, 32'h8,        32'h0,        4'h0, 32'h1, 2'b00, 2'b11};
    vecs[13] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h0, 2'b10, 2'b11};
    vecs[14] = '{1'b1, 32'h14,       32'hFFFF_FFFF, 4'hF, 32'h0, 2'b10, 2'b11};
    vecs[15] = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h3, 2'b00, 2'b11};
    vecs[16] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h3, 2'b00, 2'b11};
    vecs[17] = '{1'b1, 32'h0,        32'h3,        4'h1, 32'h0, 2'b00, 2'b00};
    vecs[18] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h0, 2'b00, 2'b00};
    vecs[19] = '{1'b0, 32'h3,        32'h0,        4'h0, 32'h0, 2'b00, 2'b00};
    vecs[20] = '{1'b1, 32'h4,        32'h1,        4'hF, 32'h0, 2'b00, 2'b00};
    vecs[21] = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h1, 2'b00, 2'b00};
    vecs[22] = '{1'b1, 32'h4,        32'h3,        4'hF, 32'h0, 2'b00, 2'b00};
    vecs[23] = '{1'b0, 32'h1000_0008, 32'h0,       4'h0, 32'h0, 2'b10, 2'b00};

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset with writerDone already high.
    irq_in = 2'b01;
    reset  = 1'b1;
    repeat (3) step();
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_irq_out", irq_out, 0);
    check("rst_irq_any", irq_any, 0);
    check("rst_rdata", bus.rdata, 0);
    reset = 1'b0;
    step();
    check("rdy_after_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("irq_out_masked", irq_out, 0);

    for (int i = 0; i < NumVec; i++) begin
      if (vecs[i].write)
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else
        axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
      check($sformatf("v%0d_irq_out", i), irq_out, vecs[i].exp_irq);
      check($sformatf("v%0d_irq_any", i), irq_any, |vecs[i].exp_irq);
    end

    // One-cycle readerDone pulse with MASK = 3, then W1C.
    irq_in = 2'b11;
    step();
    irq_in = 2'b01;
    check("pulse_irq_out_n", irq_out, 2'b00);
    step();
    check("pulse_irq_out_n1", irq_out, 2'b10);
    check("pulse_irq_any_n1", irq_any, 1);
    axi_write(32'h0, 32'h2, 4'hF, 2'b00);
    check("w1c_irq_out", irq_out, 2'b00);
    check("w1c_irq_any", irq_any, 0);

    // W1C of bit 0 in the same cycle as a rising irq_in[0]: set wins.
    irq_in = 2'b00;
    step();
    step();
    irq_in = 2'b01;
    axi_write(32'h0, 32'h1, 4'hF, 2'b00);
    axi_read(32'h0, 32'h1, 2'b00);
    axi_write(32'h0, 32'h1, 4'hF, 2'b00);
    axi_read(32'h0, 32'h0, 2'b00);

    // W three cycles ahead of AW, bready held low for five cycles.
    bus.wdata  = 32'h2;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    check("c_wready_pre", bus.wready, 1);
    step();
    bus.wvalid = 1'b0;
    check("c_wready_held", bus.wready, 0);
    step();
    step();
    check("c_no_b_yet", bus.bvalid, 0);
    e.data = '0;
    e.resp = 2'b00;
    sb_q.push_back(e);
    bus.awaddr  = 32'h4;
    bus.awvalid = 1'b1;
    check("c_awready", bus.awready, 1);
    step();
    bus.awvalid = 1'b0;
    check("c_b_latency", bus.bvalid, 1);
    pop_exp(e);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("c_bvalid_hold%0d", i), bus.bvalid, 1);
      check($sformatf("c_bresp_hold%0d", i), bus.bresp, e.resp);
      check($sformatf("c_no_awready%0d", i), {bus.awready, bus.wready}, 2'b00);
      step();
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("c_b_done", bus.bvalid, 0);
    check("c_awready_back", bus.awready, 1);
    axi_read(32'h4, 32'h2, 2'b00);

    // Reset while a read response is outstanding and interrupts are active.
    axi_write(32'h4, 32'h3, 4'hF, 2'b00);
    axi_write(32'hC, 32'h3, 4'hF, 2'b00);
    check("e_irq_out_pre", irq_out, 2'b11);
    bus.araddr  = 32'h4;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    step();
    bus.arvalid = 1'b0;
    check("e_rvalid_pending", bus.rvalid, 1);
    reset = 1'b1;
    step();
    check("e_rvalid", bus.rvalid, 0);
    check("e_bvalid", bus.bvalid, 0);
    check("e_rdata", bus.rdata, 0);
    check("e_irq_out", irq_out, 0);
    check("e_irq_any", irq_any, 0);
    check("e_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    reset = 1'b0;
    step();
    axi_read(32'h4, 32'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
